// File: rtl/pipe_skid_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encoding and
// the default payload width.
package pipe_skid_stage_reg_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Encoding doubles as the stored-entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_stage_reg_if.sv
// Handshake bundle between an upstream producer, the stage and a downstream
// consumer. The slave modport is the stage's view.
interface pipe_skid_stage_reg_if
  import pipe_skid_stage_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  i_Flush;
  logic                  i_Freeze;
  logic                  i_Valid;
  logic [DATA_WIDTH-1:0] i_Data;
  logic                  o_Ready;
  logic                  o_Valid;
  logic [DATA_WIDTH-1:0] o_Data;
  logic                  i_Ready;
  logic [1:0]            o_Count;

  modport master (
    output i_Flush, i_Freeze, i_Valid, i_Data, i_Ready,
    input  o_Ready, o_Valid, o_Data, o_Count
  );

  modport slave (
    input  i_Flush, i_Freeze, i_Valid, i_Data, i_Ready,
    output o_Ready, o_Valid, o_Data, o_Count
  );

endinterface

// File: rtl/pipe_skid_stage_reg_data_reg.sv
// Payload register with async reset, load enable and a synchronous clear
// back to the reset value; clear wins over load.
module pipe_data_reg
  import pipe_skid_stage_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (clear) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage_reg.sv
// One elastic pipeline stage: registered valid/ready handshake with a 2-entry
// skid buffer so upstream ready never depends combinationally on downstream.
module pipe_skid_stage_reg
  import pipe_skid_stage_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0,
  parameter bit                    FLUSH_CLEARS_DATA = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  pipe_skid_stage_reg_if.slave bus
);

  stage_state_e          state_q;
  stage_state_e          state_d;
  logic                  ready_en_q;
  logic                  main_v;
  logic                  skid_v;
  logic                  accept;
  logic                  drain;
  logic                  main_load;
  logic                  main_from_skid;
  logic                  skid_load;
  logic                  data_clear;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] main_d;

  // ready_en_q keeps o_Ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  assign main_v = (state_q != ST_EMPTY);
  assign skid_v = (state_q == ST_SKID);

  assign bus.o_Ready = ready_en_q & ~skid_v & ~bus.i_Flush & ~bus.i_Freeze;
  assign bus.o_Valid = main_v & ~bus.i_Flush & ~bus.i_Freeze;
  assign bus.o_Data  = main_q;
  assign bus.o_Count = state_q;

  assign accept = bus.i_Valid & bus.o_Ready;
  assign drain  = bus.o_Valid & bus.i_Ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    data_clear     = 1'b0;
    if (bus.i_Flush) begin
      state_d    = ST_EMPTY;
      data_clear = FLUSH_CLEARS_DATA;
    end else if (!bus.i_Freeze) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // The skid entry is the younger one, so it moves up on drain.
          if (drain) begin
            state_d        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.i_Data;

  pipe_data_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (data_clear),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (data_clear),
    .d     (bus.i_Data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// Drives two stage instances in lockstep (32-bit clearing, 8-bit holding with
// reset value FF) and compares both against a FIFO-queue reference model.
module tb_pipe_skid_stage_reg;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_skid_stage_reg_if #(.DATA_WIDTH(32)) busA ();
  pipe_skid_stage_reg_if #(.DATA_WIDTH(8))  busB ();

  pipe_skid_stage_reg #(
    .DATA_WIDTH        (32),
    .RESET_VALUE       (32'h0),
    .FLUSH_CLEARS_DATA (1'b1)
  ) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  pipe_skid_stage_reg #(
    .DATA_WIDTH        (8),
    .RESET_VALUE       (8'hFF),
    .FLUSH_CLEARS_DATA (1'b0)
  ) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  // Model: queue of stored entries (oldest first) plus the value o_Data shows.
  logic [31:0] modelQ[$];
  logic [31:0] shownA;
  logic [7:0]  shownB;
  bit          live;
  int          checks = 0;
  int          passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic compareCycle(input bit flush, input bit freeze);
    bit          gate;
    int          n;
    logic [31:0] headA;
    logic [7:0]  headB;
    gate  = flush | freeze;
    n     = modelQ.size();
    headA = (n > 0) ? modelQ[0] : shownA;
    headB = (n > 0) ? modelQ[0][7:0] : shownB;
    checkOutput("a_ready", 32'(busA.o_Ready), 32'(live && n < 2 && !gate));
    checkOutput("a_valid", 32'(busA.o_Valid), 32'(n > 0 && !gate));
    checkOutput("a_data",  busA.o_Data, headA);
    checkOutput("a_count", 32'(busA.o_Count), 32'(n));
    checkOutput("b_valid", 32'(busB.o_Valid), 32'(n > 0 && !gate));
    checkOutput("b_data",  32'(busB.o_Data), 32'(headB));
  endtask

  task automatic applyStimulus(input bit valid, input logic [31:0] data,
                               input bit ready, input bit flush, input bit freeze);
    bit acc;
    bit drn;
    busA.i_Valid = valid;  busB.i_Valid = valid;
    busA.i_Data  = data;   busB.i_Data  = data[7:0];
    busA.i_Ready = ready;  busB.i_Ready = ready;
    busA.i_Flush = flush;  busB.i_Flush = flush;
    busA.i_Freeze = freeze; busB.i_Freeze = freeze;
    #1;
    compareCycle(flush, freeze);
    @(posedge clk);
    if (flush) begin
      modelQ.delete();
      shownA = 32'h0;
    end else if (!freeze && live) begin
      acc = valid && (modelQ.size() < 2);
      drn = ready && (modelQ.size() > 0);
      if (drn) void'(modelQ.pop_front());
      if (acc) modelQ.push_back(data);
      if (modelQ.size() > 0) begin
        shownA = modelQ[0];
        shownB = modelQ[0][7:0];
      end
    end
    @(negedge clk);
  endtask

  task automatic driveIdle();
    busA.i_Valid = 1'b0; busA.i_Data = '0; busA.i_Ready = 1'b0;
    busA.i_Flush = 1'b0; busA.i_Freeze = 1'b0;
    busB.i_Valid = 1'b0; busB.i_Data = '0; busB.i_Ready = 1'b0;
    busB.i_Flush = 1'b0; busB.i_Freeze = 1'b0;
  endtask

  task automatic modelReset();
    modelQ.delete();
    shownA = 32'h0;
    shownB = 8'hFF;
    live   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    driveIdle();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_a_valid", 32'(busA.o_Valid), 32'h0);
    checkOutput("rst_a_ready", 32'(busA.o_Ready), 32'h0);
    checkOutput("rst_a_count", 32'(busA.o_Count), 32'h0);
    checkOutput("rst_a_data",  busA.o_Data, 32'h0);
    checkOutput("rst_b_data",  32'(busB.o_Data), 32'hFF);
    reset = 1'b0;
    @(posedge clk);
    live = 1'b1;
    @(negedge clk);

    // Streaming at full rate
    applyStimulus(1, 32'h10, 1, 0, 0);
    applyStimulus(1, 32'h11, 1, 0, 0);
    applyStimulus(1, 32'h12, 1, 0, 0);
    applyStimulus(0, 32'h0,  1, 0, 0);
    applyStimulus(0, 32'h0,  1, 0, 0);

    // Back-pressure into the skid entry
    applyStimulus(1, 32'h20, 1, 0, 0);
    applyStimulus(1, 32'h21, 0, 0, 0);
    applyStimulus(1, 32'h22, 0, 0, 0);
    applyStimulus(1, 32'h22, 1, 0, 0);
    applyStimulus(1, 32'h22, 1, 0, 0);
    applyStimulus(0, 32'h0,  1, 0, 0);
    applyStimulus(0, 32'h0,  1, 0, 0);

    // Flush while full of two entries, with a payload offered
    applyStimulus(1, 32'hA0, 0, 0, 0);
    applyStimulus(1, 32'hA1, 0, 0, 0);
    applyStimulus(1, 32'hA2, 1, 1, 0);
    applyStimulus(0, 32'h0,  1, 0, 0);

    // Freeze for three cycles
    applyStimulus(1, 32'h55, 0, 0, 0);
    applyStimulus(1, 32'h56, 1, 0, 1);
    applyStimulus(1, 32'h56, 1, 0, 1);
    applyStimulus(1, 32'h56, 1, 0, 1);
    applyStimulus(0, 32'h0,  1, 0, 0);
    applyStimulus(0, 32'h0,  1, 0, 0);

    // Flush and freeze together: flush wins; B keeps its payload
    applyStimulus(1, 32'h77, 0, 0, 0);
    applyStimulus(1, 32'h78, 1, 1, 1);
    checkOutput("ff_a_count", 32'(busA.o_Count), 32'h0);
    checkOutput("ff_a_data",  busA.o_Data, 32'h0);
    checkOutput("ff_b_count", 32'(busB.o_Count), 32'h0);
    checkOutput("ff_b_data",  32'(busB.o_Data), 32'h77);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Async reset in the middle of a cycle while holding two entries
    applyStimulus(1, 32'h31, 0, 0, 0);
    applyStimulus(1, 32'h32, 0, 0, 0);
    checkOutput("ar_b_count_pre", 32'(busB.o_Count), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_b_valid", 32'(busB.o_Valid), 32'h0);
    checkOutput("ar_b_data",  32'(busB.o_Data), 32'hFF);
    checkOutput("ar_b_count", 32'(busB.o_Count), 32'h0);
    checkOutput("ar_b_ready", 32'(busB.o_Ready), 32'h0);
    checkOutput("ar_a_data",  busA.o_Data, 32'h0);
    driveIdle();
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    live = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3, 0) != 0, $urandom(),
                    $urandom_range(2, 0) != 0,
                    $urandom_range(19, 0) == 0,
                    $urandom_range(9, 0) == 0);
    end
    applyStimulus(0, 32'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
